// File: rtl/rvv_mask_pkg.sv
// Shared types and helpers for the RVV mask-reduction engines.
package rvv_mask_pkg;

  // Mask reduction opcode carried on i_op.
  typedef enum logic [0:0] {
    MASK_VCPOP  = 1'b0,
    MASK_VFIRST = 1'b1
  } mask_op_e;

  // Sequencer state.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } mask_state_e;

  // vfirst.m result when no active bit is set (-1).
  localparam logic [63:0] VFIRST_NONE = '1;

  // Widest slice the lowest-set-bit finder supports; narrower slices are zero-extended.
  localparam int unsigned LSB_MAX_W = 256;

  // Index of the lowest set bit of v; returns 0 when v is zero.
  function automatic int unsigned lsb_index(input logic [LSB_MAX_W-1:0] v);
    int unsigned idx;
    logic        seen;
    idx  = 0;
    seen = 1'b0;
    for (int unsigned i = 0; i < LSB_MAX_W; i++) begin
      if (v[i] && !seen) begin
        idx  = i;
        seen = 1'b1;
      end
    end
    return idx;
  endfunction

endpackage

// File: rtl/tt_popcnt.sv
// Combinational population count of a WIDTH-bit vector.
module tt_popcnt #(
  parameter  int unsigned WIDTH = 64,
  localparam int unsigned OUT_W = $clog2(WIDTH) + 1
) (
  input  logic [WIDTH-1:0] data,
  output logic [OUT_W-1:0] count
);

  // Sum of all set bits; synthesis balances this into an adder tree.
  always_comb begin
    count = '0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      count = count + OUT_W'(data[i]);
    end
  end

endmodule

// File: rtl/tt_mask_cnt_seq.sv
// Sequential vcpop.m / vfirst.m engine: walks a VLEN-bit mask CHUNK bits per cycle.
module tt_mask_cnt_seq
  import rvv_mask_pkg::*;
#(
  parameter int unsigned VLEN  = 256,
  parameter int unsigned CHUNK = 64,
  parameter int unsigned XLEN  = 64,
  parameter int unsigned CNT_W = $clog2(VLEN) + 1
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_req_valid,
  output logic             o_req_ready,
  input  logic             i_op,
  input  logic             i_vm,
  input  logic [CNT_W-1:0] i_vl,
  input  logic [VLEN-1:0]  i_src,
  input  logic [VLEN-1:0]  i_mask,
  output logic             o_rsp_valid,
  input  logic             i_rsp_ready,
  output logic [XLEN-1:0]  o_rsp_data
);

  localparam int unsigned NSLICE   = VLEN / CHUNK;
  localparam int unsigned IDX_W    = (NSLICE > 1) ? $clog2(NSLICE) : 1;
  localparam int unsigned CHUNK_LG = $clog2(CHUNK);
  localparam int unsigned PC_W     = $clog2(CHUNK) + 1;

  mask_state_e      state_q, state_d;
  logic [VLEN-1:0]  eff_q;
  mask_op_e         op_q;
  logic [IDX_W-1:0] idx_q, last_q;
  logic [CNT_W-1:0] acc_q, first_q;
  logic             found_q;
  logic [XLEN-1:0]  rsp_q;

  logic             accept;
  mask_op_e         op_in;
  logic [CNT_W-1:0] vl_c;
  logic [VLEN-1:0]  tail;
  logic [VLEN-1:0]  eff_in;
  logic [IDX_W-1:0] last_in;
  logic [XLEN-1:0]  empty_rsp;
  logic [CHUNK-1:0] slice;
  logic [PC_W-1:0]  pc;
  logic [CNT_W-1:0] acc_nxt;
  logic [CNT_W-1:0] first_nxt;
  logic             hit;
  logic             busy_done;
  logic [XLEN-1:0]  busy_rsp;

  // Request-side decode: clamp vl, build the effective mask and the last slice index.
  always_comb begin
    accept  = i_req_valid && (state_q == IDLE);
    op_in   = mask_op_e'(i_op);
    vl_c    = (i_vl > CNT_W'(VLEN)) ? CNT_W'(VLEN) : i_vl;
    for (int unsigned k = 0; k < VLEN; k++) begin
      tail[k] = (CNT_W'(k) < vl_c);
    end
    eff_in    = i_src & (i_vm ? {VLEN{1'b1}} : i_mask) & tail;
    last_in   = IDX_W'((vl_c - CNT_W'(1)) >> CHUNK_LG);
    empty_rsp = (op_in == MASK_VFIRST) ? XLEN'(VFIRST_NONE) : '0;
  end

  // The low CHUNK bits of the shifting mask are always the current slice.
  assign slice = eff_q[CHUNK-1:0];

  tt_popcnt #(
    .WIDTH(CHUNK)
  ) u_popcnt (
    .data (slice),
    .count(pc)
  );

  // Per-slice accumulation, first-hit detection and result formation.
  always_comb begin
    acc_nxt   = acc_q + CNT_W'(pc);
    hit       = (op_q == MASK_VFIRST) && !found_q && (slice != '0);
    first_nxt = (CNT_W'(idx_q) << CHUNK_LG) | CNT_W'(lsb_index(LSB_MAX_W'(slice)));
    busy_done = (idx_q == last_q) || hit;
    if (op_q == MASK_VCPOP) begin
      busy_rsp = XLEN'(acc_nxt);
    end else if (hit) begin
      busy_rsp = XLEN'(first_nxt);
    end else if (found_q) begin
      busy_rsp = XLEN'(first_q);
    end else begin
      busy_rsp = XLEN'(VFIRST_NONE);
    end
  end

  // State register.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = (vl_c == '0) ? DONE : BUSY;
        end
      end
      BUSY: begin
        if (busy_done) begin
          state_d = DONE;
        end
      end
      DONE: begin
        if (i_rsp_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs decoded from the state register and the held result.
  always_comb begin
    o_req_ready = (state_q == IDLE);
    o_rsp_valid = (state_q == DONE);
    o_rsp_data  = rsp_q;
  end

  // Datapath: capture on accept, walk slices in BUSY, hold result through DONE.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      eff_q   <= '0;
      op_q    <= MASK_VCPOP;
      idx_q   <= '0;
      last_q  <= '0;
      acc_q   <= '0;
      first_q <= '0;
      found_q <= 1'b0;
      rsp_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            eff_q   <= eff_in;
            op_q    <= op_in;
            last_q  <= last_in;
            idx_q   <= '0;
            acc_q   <= '0;
            first_q <= '0;
            found_q <= 1'b0;
            if (vl_c == '0) begin
              rsp_q <= empty_rsp;
            end
          end
        end
        BUSY: begin
          eff_q <= eff_q >> CHUNK;
          idx_q <= idx_q + IDX_W'(1);
          acc_q <= acc_nxt;
          if (hit) begin
            found_q <= 1'b1;
            first_q <= first_nxt;
          end
          if (busy_done) begin
            rsp_q <= busy_rsp;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_tt_mask_cnt_seq.sv
// Self-checking bench for tt_mask_cnt_seq against a bit-level reference model.
module tb_tt_mask_cnt_seq;

  localparam int unsigned VLEN  = 256;
  localparam int unsigned CHUNK = 64;
  localparam int unsigned XLEN  = 64;
  localparam int unsigned CNT_W = $clog2(VLEN) + 1;

  logic             clk;
  logic             rst;
  logic             req_valid;
  logic             req_ready;
  logic             op;
  logic             vm;
  logic [CNT_W-1:0] vl;
  logic [VLEN-1:0]  src;
  logic [VLEN-1:0]  mask;
  logic             rsp_valid;
  logic             rsp_ready;
  logic [XLEN-1:0]  rsp_data;

  int n_checks;
  int n_fail;

  tt_mask_cnt_seq #(
    .VLEN (VLEN),
    .CHUNK(CHUNK),
    .XLEN (XLEN),
    .CNT_W(CNT_W)
  ) dut (
    .i_clk      (clk),
    .i_reset    (rst),
    .i_req_valid(req_valid),
    .o_req_ready(req_ready),
    .i_op       (op),
    .i_vm       (vm),
    .i_vl       (vl),
    .i_src      (src),
    .i_mask     (mask),
    .o_rsp_valid(rsp_valid),
    .i_rsp_ready(rsp_ready),
    .o_rsp_data (rsp_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference: result and accept-to-valid latency from the architectural rules.
  function automatic void model(input bit m_op, input bit m_vm, input int m_vl,
                                input logic [VLEN-1:0] m_src, input logic [VLEN-1:0] m_mask,
                                output logic [63:0] res, output int lat);
    int vlc, cnt, first, nsl;
    vlc   = (m_vl > int'(VLEN)) ? int'(VLEN) : m_vl;
    cnt   = 0;
    first = -1;
    for (int k = 0; k < vlc; k++) begin
      if (m_src[k] && (m_vm || m_mask[k])) begin
        cnt++;
        if (first < 0) first = k;
      end
    end
    nsl = (vlc + int'(CHUNK) - 1) / int'(CHUNK);
    if (vlc == 0) begin
      lat = 1;
      res = m_op ? 64'hFFFF_FFFF_FFFF_FFFF : 64'd0;
    end else if (!m_op) begin
      lat = nsl + 1;
      res = 64'(cnt);
    end else begin
      lat = (first >= 0) ? first / int'(CHUNK) + 2 : nsl + 1;
      if (lat > nsl + 1) lat = nsl + 1;
      res = (first >= 0) ? 64'(first) : 64'hFFFF_FFFF_FFFF_FFFF;
    end
  endfunction

  // One full transaction with `hold` cycles of response backpressure.
  task automatic run_req(input string tag, input bit t_op, input bit t_vm, input int t_vl,
                         input logic [VLEN-1:0] t_src, input logic [VLEN-1:0] t_mask,
                         input int hold);
    logic [63:0] exp_res;
    int          exp_lat;
    int          lat;
    logic [63:0] held;
    model(t_op, t_vm, t_vl, t_src, t_mask, exp_res, exp_lat);
    @(negedge clk);
    check_eq({tag, "_req_ready"}, 64'(req_ready), 64'd1);
    req_valid = 1'b1;
    op        = t_op;
    vm        = t_vm;
    vl        = CNT_W'(t_vl);
    src       = t_src;
    mask      = t_mask;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    lat = 1;
    while (!rsp_valid && lat < 40) begin
      check_eq({tag, "_busy_ready"}, 64'(req_ready), 64'd0);
      @(posedge clk);
      #1;
      lat++;
    end
    check_eq({tag, "_valid"}, 64'(rsp_valid), 64'd1);
    check_eq({tag, "_latency"}, 64'(lat), 64'(exp_lat));
    check_eq({tag, "_data"}, rsp_data, exp_res);
    held = rsp_data;
    for (int h = 0; h < hold; h++) begin
      // A competing request during backpressure must be ignored.
      req_valid = 1'b1;
      vl        = '0;
      op        = ~t_op;
      @(posedge clk);
      #1;
      check_eq({tag, "_hold_data"}, rsp_data, held);
      check_eq({tag, "_hold_valid"}, 64'(rsp_valid), 64'd1);
      check_eq({tag, "_hold_ready"}, 64'(req_ready), 64'd0);
    end
    @(negedge clk);
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    check_eq({tag, "_post_valid"}, 64'(rsp_valid), 64'd0);
    check_eq({tag, "_post_ready"}, 64'(req_ready), 64'd1);
    @(negedge clk);
    rsp_ready = 1'b0;
  endtask

  function automatic logic [VLEN-1:0] rand_vec();
    logic [VLEN-1:0] r;
    for (int i = 0; i < int'(VLEN / 32); i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  logic [VLEN-1:0] ones;
  logic [VLEN-1:0] alt;
  logic [VLEN-1:0] v;
  logic [VLEN-1:0] rs;
  logic [VLEN-1:0] rm;

  initial begin
    n_checks  = 0;
    n_fail    = 0;
    rst       = 1'b1;
    req_valid = 1'b0;
    rsp_ready = 1'b0;
    op        = 1'b0;
    vm        = 1'b0;
    vl        = '0;
    src       = '0;
    mask      = '0;
    ones      = '1;
    alt       = {(VLEN/4){4'h5}};

    repeat (3) @(posedge clk);
    #1;
    check_eq("reset_ready", 64'(req_ready), 64'd1);
    check_eq("reset_valid", 64'(rsp_valid), 64'd0);
    check_eq("reset_data", rsp_data, 64'd0);
    @(negedge clk);
    rst = 1'b0;

    // Directed cases.
    run_req("cpop_full", 1'b0, 1'b1, 256, ones, '0, 0);
    run_req("cpop_masked", 1'b0, 1'b0, 100, ones, alt, 0);
    v = '0;
    v[130] = 1'b1;
    run_req("first_130", 1'b1, 1'b1, 256, v, '0, 0);
    run_req("first_none", 1'b1, 1'b1, 256, '0, '0, 0);
    run_req("cpop_vl0", 1'b0, 1'b1, 0, ones, '0, 0);
    run_req("first_vl0", 1'b1, 1'b1, 0, ones, '0, 0);
    run_req("cpop_clamp", 1'b0, 1'b1, 300, ones, '0, 0);
    run_req("backpressure", 1'b0, 1'b1, 200, ones, '0, 10);
    v = '0;
    v[255] = 1'b1;
    run_req("first_last_bit", 1'b1, 1'b1, 256, v, '0, 0);
    run_req("first_past_vl", 1'b1, 1'b1, 255, v, '0, 0);

    // Reset during BUSY discards the transaction.
    @(negedge clk);
    req_valid = 1'b1;
    op        = 1'b0;
    vm        = 1'b1;
    vl        = CNT_W'(256);
    src       = ones;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    check_eq("midreset_ready", 64'(req_ready), 64'd1);
    check_eq("midreset_valid", 64'(rsp_valid), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk);
      #1;
      check_eq("midreset_no_rsp", 64'(rsp_valid), 64'd0);
    end
    run_req("after_reset", 1'b0, 1'b1, 64, VLEN'(8'hFF), '0, 0);

    // Randomized transactions with varied density and backpressure.
    for (int t = 0; t < 60; t++) begin
      rs = rand_vec();
      rm = rand_vec();
      case ($urandom_range(0, 3))
        0: ;
        1: rs = rs & rand_vec() & rand_vec() & rand_vec();
        2: begin rs = '0; rs[$urandom_range(0, VLEN-1)] = 1'b1; end
        default: rs = '0;
      endcase
      run_req("rand", 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
              int'($urandom_range(0, 320)), rs, rm, int'($urandom_range(0, 3)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
